// File: rtl/shared_counter_pkg.sv
// Shared definitions for the shared counter arbiter: opcodes and FSM state encodings.
package shared_counter_pkg;

  localparam int OP_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_INC  = 2'b00,
    OP_CLR  = 2'b01,
    OP_LOAD = 2'b10,
    OP_READ = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_ACK  = 2'b10
  } state_e;

endpackage

// File: rtl/shared_counter_arbiter_if.sv
// Requester-side bus of the shared counter: per-requester request/opcode/load value and the shared responses.
interface shared_counter_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
);

  logic [NUM_REQ-1:0]       req;
  logic [2*NUM_REQ-1:0]     op;
  logic [WIDTH*NUM_REQ-1:0] load_data;
  logic [NUM_REQ-1:0]       grant;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         rd_data;
  logic [WIDTH-1:0]         count;

  modport master (
    output req, op, load_data,
    input  grant, ack, rd_data, count
  );

  modport slave (
    input  req, op, load_data,
    output grant, ack, rd_data, count
  );

endinterface

// File: rtl/shared_counter_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first set request at or above the pointer, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] pointer_i,
  output logic [NUM_REQ-1:0]         grant_o
);

  localparam int PW = $clog2(NUM_REQ);

  logic          found;
  int            cand;
  logic [PW-1:0] candIdx;

  // Walk the requesters starting at the pointer; the modulo keeps non-power-of-two counts in range.
  always_comb begin
    grant_o = '0;
    found   = 1'b0;
    cand    = 0;
    candIdx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand    = (int'(pointer_i) + k) % NUM_REQ;
      candIdx = PW'(cand);
      if (!found && req_i[candIdx]) begin
        grant_o[candIdx] = 1'b1;
        found            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_counter_arbiter.sv
// Shares one wide counter among NUM_REQ requesters via round-robin arbitration and an IDLE/EXEC/ACK FSM.
// Define SHARED_COUNTER_SATURATE_EN to make INC saturate at all-ones instead of wrapping.
module shared_counter_arbiter
  import shared_counter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  shared_counter_arbiter_if.slave  bus
);

  localparam int IDXW = $clog2(NUM_REQ);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [IDXW-1:0]    ptr_q, ptr_d;
  logic [IDXW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   rd_data_q, rd_data_d;

  logic [NUM_REQ-1:0] arbGrant;
  logic [IDXW-1:0]    arbIdx;
  op_e                execOp;
  logic [WIDTH-1:0]   loadValue;
  logic [WIDTH-1:0]   execValue;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i    (bus.req),
    .pointer_i(ptr_q),
    .grant_o  (arbGrant)
  );

  always_comb begin
    arbIdx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arbGrant[i]) arbIdx = IDXW'(i);
    end
  end

  // Opcode and load value are taken from the owner's slice only at the EXEC edge.
  always_comb begin
    execOp    = op_e'(bus.op[2*idx_q +: 2]);
    loadValue = bus.load_data[WIDTH*idx_q +: WIDTH];
    execValue = count_q;
    unique case (execOp)
      OP_INC: begin
`ifdef SHARED_COUNTER_SATURATE_EN
        if (&count_q) execValue = count_q;
        else          execValue = count_q + WIDTH'(1);
`else
        execValue = count_q + WIDTH'(1);
`endif
      end
      OP_CLR:  execValue = '0;
      OP_LOAD: execValue = loadValue;
      OP_READ: execValue = count_q;
      default: execValue = count_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ack_d     = '0;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.req) begin
          grant_d = arbGrant;
          idx_d   = arbIdx;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        count_d   = execValue;
        rd_data_d = execValue;
        ack_d     = grant_q;
        state_d   = ST_ACK;
      end
      ST_ACK: begin
        grant_d = '0;
        ptr_d   = (idx_q == IDXW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ack_q     <= '0;
      ptr_q     <= '0;
      idx_q     <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.ack     = ack_q;
  assign bus.rd_data = rd_data_q;
  assign bus.count   = count_q;

endmodule
